alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational alu instance between NUM_REQ requesters (fetch/AGU/exec slots).
//  Round-robin grant, operands registered into the ALU, result/zero registered and returned
//  with the requester ID over a valid/ready response channel. One operation in flight at a time.
// PARAMETERS
//  WIDTH    32  operand/result width; must equal the alu instance WIDTH
//  NUM_REQ  4   number of requesters, 2..8
//  ID_W     $clog2(NUM_REQ)  localparam, requester ID width
// PORTS
//  clk          in   1               rising-edge clock
//  rst          in   1               synchronous, active-high reset
//  req_valid    in   NUM_REQ         per-requester request valid
//  req_ready    out  NUM_REQ         per-requester accept; one-hot or zero
//  req_a        in   NUM_REQ*WIDTH   operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b        in   NUM_REQ*WIDTH   operand B, same packing
//  req_op       in   NUM_REQ*3       alu_control code, requester i at [i*3 +: 3]
//  alu_a        out  WIDTH           to alu.a
//  alu_b        out  WIDTH           to alu.b
//  alu_control  out  3               to alu.alu_control
//  alu_result   in   WIDTH           from alu.result
//  alu_zero     in   1               from alu.zero
//  rsp_valid    out  1               response valid
//  rsp_ready    in   1               response accept
//  rsp_id       out  ID_W            requester that issued the op
//  rsp_result   out  WIDTH           registered ALU result
//  rsp_zero     out  1               registered ALU zero flag
//  rsp_err      out  1               illegal op code (3'b110/3'b111)
// BEHAVIOUR
//  - Ops: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL (alu semantics unchanged).
//  - FSM IDLE -> EXEC -> RESP -> IDLE. Reset: IDLE, rr_ptr = NUM_REQ-1 (req 0 has top priority),
//    req_ready=0, rsp_valid=0, rsp_id/result/zero/err=0, alu_a/alu_b/alu_control=0.
//  - IDLE: if any req_valid, grant g = first valid at or after (rr_ptr+1) mod NUM_REQ;
//    req_ready[g]=1 combinationally this cycle only; capture a/b/op/g; rr_ptr<=g; -> EXEC.
//    No req_valid: remain in IDLE, req_ready=0.
//  - req_ready is 0 in EXEC and RESP. Requesters hold valid and operands until ready.
//  - EXEC (1 cycle): alu_* driven from capture regs; on the edge capture alu_result/alu_zero
//    into rsp regs; -> RESP.
//  - Illegal op: still goes through EXEC; rsp_result=0, rsp_zero=1, rsp_err=1; ALU output ignored.
//  - RESP: rsp_valid=1, rsp_* stable; on rsp_valid&&rsp_ready -> IDLE, rsp_valid=0 next cycle.
//    Backpressure holds RESP indefinitely; no new grant while in RESP.
//  - Latency: grant edge -> rsp_valid 2 cycles later; min issue interval 3 cycles.
//  - alu_* hold last operands outside EXEC (no toggling in IDLE/RESP).
//  - rr_ptr wrap: ptr NUM_REQ-1 -> search starts at 0. A single requester is granted every turn.
//  - Widths: no truncation; SHL amount is the alu's own use of b.
//  - rst during any state: next cycle IDLE with reset values; in-flight op dropped, no response.
// STRUCTURE
//  - alu_pkg: alu_op_e enum (ALU_ADD..ALU_SHL), ALU_OP_W=3, is_legal_op() function,
//    arb_state_e {ST_IDLE, ST_EXEC, ST_RESP}.
//  - Sub-module rr_arbiter #(N): combinational req vector + ptr -> one-hot grant + grant index.
//  - Top: FSM, capture regs, response regs; alu instantiated by parent, not inside this block.
// TESTING (bench instantiates alu #(32) and alu_share_arbiter #(32,4))
//  1. After reset, only req1 valid, a=5 b=3 op=000 -> req_ready[1] 1 cycle; 2 cycles later
//     rsp_valid, rsp_id=1, rsp_result=8, rsp_zero=0, rsp_err=0.
//  2. All 4 valid, op=001 a=10 b=4 (hold, rsp_ready=1) -> grants in order 0,1,2,3,0; each
//     result 6; grant spacing 3 cycles.
//  3. req2 a=7 b=7 op=001, rsp_ready=0 for 5 cycles -> rsp_valid held, result 0, zero=1,
//     no req_ready pulse while held; accepts next request after handshake.
//  4. req0 op=3'b111 -> rsp_err=1, rsp_result=0, rsp_zero=1; op=101 a=1 b=2 -> result 4.
//  5. rst asserted in EXEC -> no rsp_valid afterwards, rr_ptr restored (req0 wins a 0/3 tie).
//  6. req3 only, back-to-back AND a=0xAA b=0x0F -> result 0x0A each time, rsp_id=3 every time.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, legality check and arbiter state encoding
package alu_pkg;
  localparam int ALU_OP_W = 3;
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SHL = 3'b101
  } alu_op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} arb_state_e;
  function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
    return op <= ALU_SHL;
  endfunction
endpackage

// File: rtl/alu.sv
// alu: combinational ALU shared by the arbiter; shifts by the low log2(WIDTH) bits of b
module alu import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [ALU_OP_W-1:0] alu_control,
  output logic [WIDTH-1:0]    result,
  output logic                zero
);
  // op decode; illegal codes yield zero
  always_comb begin
    case (alu_control)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SHL: result = a << b[$clog2(WIDTH)-1:0];
      default: result = '0;
    endcase
  end
  assign zero = result == '0;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first requester at or after ptr+1 (mod N), one-hot plus index
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  int   c;
  logic found;
  // rotating priority search starting just past the last winner
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    c = 0;
    for (int i = 1; i <= N; i++) begin
      c = (int'(ptr) + i) % N;
      if (!found && req[c]) begin
        found = 1'b1;
        grant[c] = 1'b1;
        idx = IW'(c);
      end
    end
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one external ALU with a registered valid/ready response
module alu_share_arbiter import alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]    req_a,
  input  logic [NUM_REQ*WIDTH-1:0]    req_b,
  input  logic [NUM_REQ*ALU_OP_W-1:0] req_op,
  output logic [WIDTH-1:0]            alu_a,
  output logic [WIDTH-1:0]            alu_b,
  output logic [ALU_OP_W-1:0]         alu_control,
  input  logic [WIDTH-1:0]            alu_result,
  input  logic                        alu_zero,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_W-1:0]             rsp_id,
  output logic [WIDTH-1:0]            rsp_result,
  output logic                        rsp_zero,
  output logic                        rsp_err
);
  arb_state_e          state;
  logic [ID_W-1:0]     rr_ptr, gnt_idx, cap_id;
  logic [NUM_REQ-1:0]  gnt;
  logic [WIDTH-1:0]    cap_a, cap_b;
  logic [ALU_OP_W-1:0] cap_op;
  logic                legal;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx)
  );
  assign req_ready   = (state == ST_IDLE) ? gnt : '0;
  assign rsp_valid   = state == ST_RESP;
  assign alu_a       = cap_a;
  assign alu_b       = cap_b;
  assign alu_control = cap_op;
  assign legal       = is_legal_op(cap_op);
  // grant/capture in IDLE, sample ALU in EXEC, hold response until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      rr_ptr <= ID_W'(NUM_REQ - 1);
      cap_a <= '0;
      cap_b <= '0;
      cap_op <= '0;
      cap_id <= '0;
      rsp_id <= '0;
      rsp_result <= '0;
      rsp_zero <= 1'b0;
      rsp_err <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (|req_valid) begin
        cap_a <= req_a[gnt_idx*WIDTH +: WIDTH];
        cap_b <= req_b[gnt_idx*WIDTH +: WIDTH];
        cap_op <= req_op[gnt_idx*ALU_OP_W +: ALU_OP_W];
        cap_id <= gnt_idx;
        rr_ptr <= gnt_idx;
        state <= ST_EXEC;
      end
    end else if (state == ST_EXEC) begin
      rsp_id <= cap_id;
      rsp_result <= legal ? alu_result : '0;
      rsp_zero <= legal ? alu_zero : 1'b1;
      rsp_err <= !legal;
      state <= ST_RESP;
    end else if (rsp_ready) begin
      state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_alu_share_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req_valid, req_ready;
  logic [127:0] req_a, req_b;
  logic [11:0] req_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_control;
  logic alu_zero;
  logic rsp_valid, rsp_ready;
  logic [1:0] rsp_id;
  logic [31:0] rsp_result;
  logic rsp_zero, rsp_err;
  int total = 0, bad = 0, cyc_cnt = 0, last = 3;

  alu #(32) u_alu (.a(alu_a), .b(alu_b), .alu_control(alu_control), .result(alu_result), .zero(alu_zero));
  alu_share_arbiter #(32, 4) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_result(alu_result),
    .alu_zero(alu_zero), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic int next_grant(input logic [3:0] v, input int from);
    for (int k = 1; k <= 4; k++) if (v[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << (b % 32);
      default: return 32'd0;
    endcase
  endfunction

  task automatic after_edge;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    req_valid[i] = v;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_op[i*3 +: 3] = op;
  endtask

  task automatic wait_grant(output logic [3:0] g, output int at);
    g = '0;
    at = -1;
    for (int n = 0; n < 20 && g == '0; n++) begin
      @(negedge clk);
      if (|req_ready) begin
        g = req_ready;
        at = cyc_cnt;
      end
    end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    for (int k = 1; k <= 20 && n == 0; k++) begin
      @(negedge clk);
      if (rsp_valid) n = k;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (req_ready !== 4'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_hs got ready=%b valid=%b exp 0/0", req_ready, rsp_valid); end
    total++; if ({rsp_id, rsp_result, rsp_zero, rsp_err} !== 36'd0) begin bad++; $display("FAIL reset_rsp got id=%0d res=%0h z=%b e=%b exp all 0", rsp_id, rsp_result, rsp_zero, rsp_err); end
    total++; if ({alu_a, alu_b, alu_control} !== 67'd0) begin bad++; $display("FAIL reset_alu got a=%0h b=%0h c=%0d exp all 0", alu_a, alu_b, alu_control); end
    after_edge;
    rst = 1'b0;
    last = 3;
  endtask

  task automatic test_single;
    logic [3:0] g;
    int at;
    set_req(1, 1'b1, 32'd5, 32'd3, 3'd0);
    rsp_ready = 1'b1;
    wait_grant(g, at);
    total++; if (g !== 4'b0010) begin bad++; $display("FAIL single_grant got=%b exp=0010", g); end
    after_edge;
    req_valid[1] = 1'b0;
    @(negedge clk);
    total++; if ({rsp_valid, req_ready, alu_a, alu_b, alu_control} !== {1'b0, 4'b0, 32'd5, 32'd3, 3'd0}) begin bad++; $display("FAIL single_exec got v=%b r=%b a=%0d b=%0d c=%0d exp 0/0/5/3/0", rsp_valid, req_ready, alu_a, alu_b, alu_control); end
    @(negedge clk);
    total++; if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err} !== {1'b1, 2'd1, 32'd8, 1'b0, 1'b0}) begin bad++; $display("FAIL single_rsp got v=%b id=%0d res=%0d z=%b e=%b exp 1/1/8/0/0", rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_drop got valid=%b exp=0", rsp_valid); end
    last = 1;
    after_edge;
  endtask

  task automatic test_all_valid;
    logic [3:0] g;
    int at, prev, n, e;
    prev = 0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 32'd10, 32'd4, 3'd1);
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      e = next_grant(req_valid, last);
      wait_grant(g, at);
      total++; if (g !== 4'(1 << e)) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", k, g, 4'(1 << e)); end
      if (k > 0) begin
        total++; if (at - prev !== 3) begin bad++; $display("FAIL rr_spacing%0d got=%0d exp=3", k, at - prev); end
      end
      prev = at;
      wait_rsp(n);
      total++; if ({n == 2, rsp_id, rsp_result, rsp_zero, rsp_err} !== {1'b1, 2'(e), 32'd6, 1'b0, 1'b0}) begin bad++; $display("FAIL rr_rsp%0d got lat=%0d id=%0d res=%0d z=%b e=%b exp 2/%0d/6/0/0", k, n, rsp_id, rsp_result, rsp_zero, rsp_err, e); end
      last = e;
    end
    req_valid = '0;
    after_edge;
  endtask

  task automatic test_backpressure;
    logic [3:0] g;
    int at, n;
    rsp_ready = 1'b0;
    set_req(2, 1'b1, 32'd7, 32'd7, 3'd1);
    wait_grant(g, at);
    total++; if (g !== 4'b0100) begin bad++; $display("FAIL bp_grant got=%b exp=0100", g); end
    after_edge;
    req_valid[2] = 1'b0;
    set_req(0, 1'b1, 32'd1, 32'd1, 3'd0);
    wait_rsp(n);
    total++; if ({n == 2, rsp_id, rsp_result, rsp_zero, rsp_err} !== {1'b1, 2'd2, 32'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL bp_rsp got lat=%0d id=%0d res=%0d z=%b e=%b exp 2/2/0/1/0", n, rsp_id, rsp_result, rsp_zero, rsp_err); end
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      total++; if ({rsp_valid, req_ready, rsp_result, rsp_zero} !== {1'b1, 4'b0, 32'd0, 1'b1}) begin bad++; $display("FAIL bp_hold%0d got v=%b r=%b res=%0d z=%b exp 1/0/0/1", h, rsp_valid, req_ready, rsp_result, rsp_zero); end
    end
    after_edge;
    rsp_ready = 1'b1;
    wait_grant(g, at);
    total++; if (g !== 4'(1 << next_grant(4'b0001, 2))) begin bad++; $display("FAIL bp_next got=%b exp=0001", g); end
    after_edge;
    req_valid[0] = 1'b0;
    wait_rsp(n);
    total++; if ({rsp_id, rsp_result, rsp_zero, rsp_err} !== {2'd0, 32'd2, 1'b0, 1'b0}) begin bad++; $display("FAIL bp_next_rsp got id=%0d res=%0d z=%b e=%b exp 0/2/0/0", rsp_id, rsp_result, rsp_zero, rsp_err); end
    last = 0;
    after_edge;
  endtask

  task automatic test_illegal;
    logic [3:0] g;
    int at, n;
    set_req(0, 1'b1, 32'd9, 32'd9, 3'b111);
    wait_grant(g, at);
    total++; if (g !== 4'b0001) begin bad++; $display("FAIL ill_grant got=%b exp=0001", g); end
    after_edge;
    req_valid[0] = 1'b0;
    wait_rsp(n);
    total++; if ({rsp_id, rsp_result, rsp_zero, rsp_err} !== {2'd0, 32'd0, 1'b1, 1'b1}) begin bad++; $display("FAIL ill_rsp got id=%0d res=%0h z=%b e=%b exp 0/0/1/1", rsp_id, rsp_result, rsp_zero, rsp_err); end
    after_edge;
    set_req(0, 1'b1, 32'd1, 32'd2, 3'd5);
    wait_grant(g, at);
    after_edge;
    req_valid[0] = 1'b0;
    wait_rsp(n);
    total++; if ({g, rsp_result, rsp_zero, rsp_err} !== {4'b0001, 32'd4, 1'b0, 1'b0}) begin bad++; $display("FAIL shl_rsp got g=%b res=%0d z=%b e=%b exp 0001/4/0/0", g, rsp_result, rsp_zero, rsp_err); end
    last = 0;
    after_edge;
  endtask

  task automatic test_reset_exec;
    logic [3:0] g;
    int at, n;
    set_req(0, 1'b1, 32'd1, 32'd2, 3'd0);
    set_req(3, 1'b1, 32'd3, 32'd4, 3'd0);
    wait_grant(g, at);
    total++; if (g !== 4'(1 << next_grant(4'b1001, last))) begin bad++; $display("FAIL rx_grant got=%b exp=1000", g); end
    after_edge;
    rst = 1'b1;
    req_valid = '0;
    after_edge;
    rst = 1'b0;
    for (int h = 0; h < 4; h++) begin
      @(negedge clk);
      total++; if ({rsp_valid, req_ready, alu_a} !== 37'd0) begin bad++; $display("FAIL rx_quiet%0d got v=%b r=%b a=%0h exp 0/0/0", h, rsp_valid, req_ready, alu_a); end
    end
    after_edge;
    req_valid = 4'b1001;
    wait_grant(g, at);
    total++; if (g !== 4'(1 << next_grant(4'b1001, 3))) begin bad++; $display("FAIL rx_tie got=%b exp=0001", g); end
    after_edge;
    req_valid = '0;
    wait_rsp(n);
    total++; if ({rsp_id, rsp_result} !== {2'd0, 32'd3}) begin bad++; $display("FAIL rx_rsp got id=%0d res=%0d exp 0/3", rsp_id, rsp_result); end
    last = 0;
    after_edge;
  endtask

  task automatic test_back_to_back;
    logic [3:0] g;
    int at, prev, n;
    prev = 0;
    set_req(3, 1'b1, 32'hAA, 32'h0F, 3'd2);
    for (int k = 0; k < 3; k++) begin
      wait_grant(g, at);
      total++; if (g !== 4'b1000) begin bad++; $display("FAIL b2b_grant%0d got=%b exp=1000", k, g); end
      if (k > 0) begin
        total++; if (at - prev !== 3) begin bad++; $display("FAIL b2b_spacing%0d got=%0d exp=3", k, at - prev); end
      end
      prev = at;
      wait_rsp(n);
      total++; if ({n == 2, rsp_id, rsp_result, rsp_zero, rsp_err} !== {1'b1, 2'd3, 32'h0A, 1'b0, 1'b0}) begin bad++; $display("FAIL b2b_rsp%0d got lat=%0d id=%0d res=%0h z=%b e=%b exp 2/3/a/0/0", k, n, rsp_id, rsp_result, rsp_zero, rsp_err); end
    end
    req_valid = '0;
    last = 3;
    after_edge;
  endtask

  task automatic test_random;
    logic busy;
    int drop, since, e, eid;
    logic [31:0] eres;
    logic ez, ee;
    logic [3:0] er;
    rst = 1'b1;
    req_valid = '0;
    after_edge;
    rst = 1'b0;
    last = 3;
    busy = 1'b0;
    drop = -1;
    since = 0;
    eid = 0;
    eres = '0;
    ez = 1'b0;
    ee = 1'b0;
    for (int t = 0; t < 400; t++) begin
      after_edge;
      if (drop >= 0) req_valid[drop] = 1'b0;
      drop = -1;
      for (int i = 0; i < 4; i++)
        if (!req_valid[i] && $urandom_range(0, 3) == 0)
          set_req(i, 1'b1, $urandom, ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)), 3'($urandom_range(0, 7)));
      rsp_ready = $urandom_range(0, 2) != 0;
      @(negedge clk);
      if (!busy) begin
        e = next_grant(req_valid, last);
        er = (e >= 0) ? 4'(1 << e) : 4'b0;
        total++; if (req_ready !== er || rsp_valid !== 1'b0) begin bad++; $display("FAIL rnd_grant t=%0d got r=%b v=%b exp r=%b v=0", t, req_ready, rsp_valid, er); end
        if (e >= 0) begin
          eid = e;
          ee = req_op[e*3 +: 3] > 3'd5;
          eres = ee ? 32'd0 : ref_alu(req_op[e*3 +: 3], req_a[e*32 +: 32], req_b[e*32 +: 32]);
          ez = ee ? 1'b1 : (eres == 32'd0);
          busy = 1'b1;
          since = 0;
          last = e;
          drop = e;
        end
      end else begin
        since++;
        if (since == 1) begin
          total++; if ({req_ready, rsp_valid} !== 5'd0) begin bad++; $display("FAIL rnd_exec t=%0d got r=%b v=%b exp 0/0", t, req_ready, rsp_valid); end
        end else begin
          total++; if ({req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err} !== {4'b0, 1'b1, 2'(eid), eres, ez, ee}) begin bad++; $display("FAIL rnd_rsp t=%0d got r=%b v=%b id=%0d res=%0h z=%b e=%b exp 0/1/%0d/%0h/%b/%b", t, req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, eid, eres, ez, ee); end
          if (rsp_ready) busy = 1'b0;
        end
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) after_edge;
  endtask

  initial begin
    test_reset;
    test_single;
    test_all_valid;
    test_backpressure;
    test_illegal;
    test_reset_exec;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
